// File: rtl/gfx_cmd_pkg.sv
// gfx_cmd_pkg: opcodes and FSM state encoding shared by the graphics command engine
package gfx_cmd_pkg;
  typedef enum logic [7:0] {OP_CLEAR = 8'h01, OP_FILL = 8'h02, OP_COPY = 8'h03} op_t;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CP_RD, S_CP_WAIT, S_CP_WR, S_FINISH} state_t;
endpackage

// File: rtl/cmd_addr_gen.sv
// cmd_addr_gen: remaining-byte count and source/destination pointers for the command engine
//   load           capture cnt_in/src_in/dst_in and the direction (down)
//   step           one byte consumed: count down, move both pointers
//   dst            current destination pointer
//   src_step/dst_step  pointers as they will be after the next step
//   zero           no bytes left after the current one
module cmd_addr_gen
  import gfx_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        down,
  input  logic [15:0] cnt_in,
  input  logic [15:0] src_in,
  input  logic [15:0] dst_in,
  output logic [15:0] dst,
  output logic [15:0] src_step,
  output logic [15:0] dst_step,
  output logic        zero
);
  logic [15:0] cnt;
  logic [15:0] src;
  logic        dn;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      src <= '0;
      dst <= '0;
      dn  <= 1'b0;
    end else if (load) begin
      cnt <= cnt_in;
      src <= src_in;
      dst <= dst_in;
      dn  <= down;
    end else if (step) begin
      cnt <= cnt - 16'd1;
      src <= src_step;
      dst <= dst_step;
    end
  assign src_step = dn ? src - 16'd1 : src + 16'd1;
  assign dst_step = dn ? dst - 16'd1 : dst + 16'd1;
  assign zero     = cnt == 16'd0;
endmodule

// File: rtl/gfx_cmd_engine.sv
// gfx_cmd_engine: CLEAR / FILL / COPY engine driving screen RAM port A
//   cmd/request/user_addr/src_addr/length/fill_val  command inputs, latched on acceptance
//   cmd_mem_rdata   port A read data, valid one cycle after the address
//   cmd_mem_addr/cmd_mem_data/cmd_mem_wren  port A controls (registered)
//   active  command running; done  end-of-command pulse; err  unknown-opcode pulse
module gfx_cmd_engine
  import gfx_cmd_pkg::*;
#(
  parameter logic [15:0] SCREEN_SIZE = 16'd4800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd,
  input  logic        request,
  input  logic [15:0] user_addr,
  input  logic [15:0] src_addr,
  input  logic [15:0] length,
  input  logic [7:0]  fill_val,
  input  logic [7:0]  cmd_mem_rdata,
  output logic [15:0] cmd_mem_addr,
  output logic [7:0]  cmd_mem_data,
  output logic        cmd_mem_wren,
  output logic        active,
  output logic        done,
  output logic        err
);
  state_t      state, state_n;
  logic [15:0] addr_n, len, last, src_in, dst_in, dst, src_step, dst_step;
  logic [7:0]  data_n;
  logic        wren_n, err_n, done_n, active_n, load, step, known, down, zero;
  assign known = cmd == OP_CLEAR || cmd == OP_FILL || cmd == OP_COPY;
  assign len   = cmd == OP_CLEAR ? SCREEN_SIZE : length;
  assign last  = len - 16'd1;
  // Copy backwards when the destination lies above the source so overlapping bytes are read before overwritten
  assign down   = cmd == OP_COPY && user_addr > src_addr;
  assign src_in = down ? src_addr + last : src_addr;
  assign dst_in = cmd == OP_CLEAR ? 16'h0000 : down ? user_addr + last : user_addr;
  cmd_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .down     (down),
    .cnt_in   (last),
    .src_in   (src_in),
    .dst_in   (dst_in),
    .dst      (dst),
    .src_step (src_step),
    .dst_step (dst_step),
    .zero     (zero)
  );
  // Outputs are computed one cycle ahead and registered, so the first write appears the cycle after acceptance
  always_comb begin
    state_n = state;
    addr_n  = cmd_mem_addr;
    data_n  = cmd_mem_data;
    wren_n  = 1'b0;
    err_n   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      S_IDLE: if (request) begin
        load    = 1'b1;
        err_n   = !known;
        state_n = !known || len == 16'd0 ? S_FINISH : cmd == OP_COPY ? S_CP_RD : S_FILL;
        addr_n  = cmd == OP_COPY ? src_in : dst_in;
        data_n  = fill_val;
        wren_n  = state_n == S_FILL;
      end
      S_FILL, S_CP_WR: if (zero) state_n = S_FINISH;
      else begin
        step    = 1'b1;
        state_n = state == S_FILL ? S_FILL : S_CP_RD;
        addr_n  = state == S_FILL ? dst_step : src_step;
        wren_n  = state == S_FILL;
      end
      S_CP_RD: state_n = S_CP_WAIT;
      S_CP_WAIT: begin
        state_n = S_CP_WR;
        addr_n  = dst;
        data_n  = cmd_mem_rdata;
        wren_n  = 1'b1;
      end
      S_FINISH: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  assign done_n   = state_n == S_FINISH;
  assign active_n = state_n != S_IDLE && state_n != S_FINISH;
  always_ff @(posedge clk)
    if (rst) begin
      state        <= S_IDLE;
      cmd_mem_addr <= '0;
      cmd_mem_data <= '0;
      cmd_mem_wren <= 1'b0;
      active       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      cmd_mem_addr <= addr_n;
      cmd_mem_data <= data_n;
      cmd_mem_wren <= wren_n;
      active       <= active_n;
      done         <= done_n;
      err          <= err_n;
    end
endmodule

// File: tb/tb_gfx_cmd_engine.sv
// tb_gfx_cmd_engine: directed self-checking bench with a per-cycle reference model and screen RAM
module tb_gfx_cmd_engine;
  logic        clk = 1'b0, rst = 1'b1, request = 1'b0;
  logic [7:0]  cmd = 8'h00, fill_val = 8'h00, cmd_mem_rdata, cmd_mem_data;
  logic [15:0] user_addr = 16'h0, src_addr = 16'h0, length = 16'h0, cmd_mem_addr;
  logic        cmd_mem_wren, active, done, err;

  always #5 clk = ~clk;

  gfx_cmd_engine dut (
    .clk           (clk),
    .rst           (rst),
    .cmd           (cmd),
    .request       (request),
    .user_addr     (user_addr),
    .src_addr      (src_addr),
    .length        (length),
    .fill_val      (fill_val),
    .cmd_mem_rdata (cmd_mem_rdata),
    .cmd_mem_addr  (cmd_mem_addr),
    .cmd_mem_data  (cmd_mem_data),
    .cmd_mem_wren  (cmd_mem_wren),
    .active        (active),
    .done          (done),
    .err           (err)
  );

  // one expected output cycle: flags act,wr,dn,er, check-addr, check-data, data-from-source
  typedef struct packed {
    logic        act, wr, dn, er, ca, cd, cp;
    logic [15:0] a, s;
    logic [7:0]  d;
  } rec_t;

  rec_t        q[$];
  logic [7:0]  ram [0:65535];
  logic [7:0]  mm  [0:65535];
  int n_chk = 0, n_fail = 0, cyc = 0, n_act = 0, n_wr = 0, done_at = 0;
  int acc = 0, a_act = 0, a_wr = 0, bad;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic rec_t mk(input logic [6:0] f, input logic [15:0] a, s, input logic [7:0] d);
    return {f, a, s, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // screen RAM: synchronous write, read data one cycle after the address
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] <= pat(16'(i));
    forever @(posedge clk) begin
      if (cmd_mem_wren) ram[cmd_mem_addr] <= cmd_mem_data;
      cmd_mem_rdata <= ram[cmd_mem_addr];
    end
  end

  // compare process: one expected record per cycle, idle when the model has nothing queued
  initial begin : cmp
    rec_t e;
    for (int i = 0; i < 65536; i++) mm[i] = pat(16'(i));
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (active) n_act++;
      if (cmd_mem_wren) n_wr++;
      if (done) done_at = cyc;
      e = '0;
      if (q.size() != 0) e = q.pop_front();
      if (e.cp) e.d = mm[e.s];
      chk("ctl{active,wren,done,err}", 32'({active, cmd_mem_wren, done, err}), 32'({e.act, e.wr, e.dn, e.er}));
      if (e.ca) chk("addr", 32'(cmd_mem_addr), 32'(e.a));
      if (e.cd) chk("data", 32'(cmd_mem_data), 32'(e.d));
      if (e.wr) mm[e.a] = e.d;
    end
  end

  // expected cycle sequence of one accepted command, straight from the command definitions
  task automatic build(input logic [7:0] c, input logic [15:0] ua, sa, ln, input logic [7:0] fv);
    logic [15:0] n, o;
    logic        ok;
    ok = c == 8'h01 || c == 8'h02 || c == 8'h03;
    n  = c == 8'h01 ? 16'd4800 : ln;
    if (!ok || n == 16'd0) q.push_back(mk({3'b001, !ok, 3'b000}, 16'h0, 16'h0, 8'h0));
    else begin
      for (int k = 0; k < int'(n); k++) begin
        if (c == 8'h03) begin
          o = ua > sa ? n - 16'd1 - 16'(k) : 16'(k);
          q.push_back(mk(7'b1000100, sa + o, 16'h0, 8'h0));
          q.push_back(mk(7'b1000000, 16'h0, 16'h0, 8'h0));
          q.push_back(mk(7'b1100111, ua + o, sa + o, 8'h0));
        end else q.push_back(mk(7'b1100110, (c == 8'h01 ? 16'h0 : ua) + 16'(k), 16'h0, fv));
      end
      q.push_back(mk(7'b0010000, 16'h0, 16'h0, 8'h0));
    end
  endtask

  task automatic issue(input logic [7:0] c, input logic [15:0] ua, sa, ln, input logic [7:0] fv);
    @(negedge clk);
    cmd = c; user_addr = ua; src_addr = sa; length = ln; fill_val = fv; request = 1'b1;
    @(posedge clk);
    acc = cyc; a_act = n_act; a_wr = n_wr;
    build(c, ua, sa, ln, fv);
    @(negedge clk);
    request = 1'b0; cmd = 8'h7F; user_addr = ~ua; src_addr = ~sa; length = 16'h1234; fill_val = ~fv;
  endtask

  task automatic drain;
    for (int i = 0; i < 20000 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal;
  end

  initial begin : stim
    logic [7:0]  exp4 [4];
    logic [15:0] w;
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(posedge clk);
    q.push_back(mk(7'b0000110, 16'h0, 16'h0, 8'h0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(8'h02, 16'h0100, 16'h0000, 16'd4, 8'h41); drain;
    chk("fill_done_cycle", 32'(done_at - acc), 32'd5);
    chk("fill_active_cycles", 32'(n_act - a_act), 32'd4);
    for (int i = 0; i < 4; i++) chk("fill_ram", 32'(ram[16'(16'h0100 + i)]), 32'h41);
    chk("fill_ram_after", 32'(ram[16'h0104]), 32'h5F);

    issue(8'h02, 16'h0300, 16'h0000, 16'd2, 8'h66);
    repeat (2) @(negedge clk);
    cmd = 8'h02; user_addr = 16'h0310; length = 16'd1; fill_val = 8'h99; request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    drain;
    chk("finish_req_ignored", 32'(ram[16'h0310]), 32'h49);

    issue(8'h03, 16'h0000, 16'h0050, 16'd80, 8'h00); drain;
    chk("copy_up_active", 32'(n_act - a_act), 32'd240);
    chk("copy_up_done", 32'(done_at - acc), 32'd241);
    bad = 0;
    for (int i = 0; i < 80; i++) if (ram[16'(i)] !== pat(16'(i + 80))) bad++;
    chk("copy_up_ram", 32'(bad), 32'd0);

    for (int i = 0; i < 4; i++) begin
      issue(8'h02, 16'(i), 16'h0000, 16'd1, exp4[i]); drain;
    end
    issue(8'h03, 16'h0002, 16'h0000, 16'd4, 8'h00); drain;
    for (int i = 0; i < 4; i++) chk("copy_down_ram", 32'(ram[16'(i + 2)]), 32'(exp4[i]));
    chk("copy_down_active", 32'(n_act - a_act), 32'd12);

    issue(8'h02, 16'hFFFE, 16'h0000, 16'd3, 8'hA5); drain;
    for (int i = 0; i < 3; i++) begin
      w = 16'hFFFE + 16'(i);
      chk("wrap_ram", 32'(ram[w]), 32'hA5);
    end

    issue(8'h7F, 16'h0400, 16'h0000, 16'd5, 8'hEE); drain;
    chk("bad_op_done", 32'(done_at - acc), 32'd1);
    chk("bad_op_writes", 32'(n_wr - a_wr), 32'd0);
    issue(8'h02, 16'h0400, 16'h0000, 16'd0, 8'hEE); drain;
    chk("len0_done", 32'(done_at - acc), 32'd1);
    chk("len0_writes", 32'(n_wr - a_wr), 32'd0);
    chk("len0_ram", 32'(ram[16'h0400]), 32'h5E);
    issue(8'h03, 16'h0400, 16'h0500, 16'd0, 8'h00); drain;
    chk("copy_len0_done", 32'(done_at - acc), 32'd1);

    issue(8'h01, 16'h1234, 16'h4321, 16'd0, 8'h3C); drain;
    chk("clear_done", 32'(done_at - acc), 32'd4801);
    chk("clear_writes", 32'(n_wr - a_wr), 32'd4800);
    bad = 0;
    for (int i = 0; i < 4800; i++) if (ram[16'(i)] !== 8'h3C) bad++;
    chk("clear_ram", 32'(bad), 32'd0);
    chk("clear_ram_after", 32'(ram[16'd4800]), 32'h88);

    issue(8'h01, 16'h0000, 16'h0000, 16'd0, 8'h77);
    repeat (3) @(negedge clk);
    cmd = 8'h02; user_addr = 16'h0200; length = 16'd5; fill_val = 8'h99; request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; cmd = 8'h02; user_addr = 16'h0200; length = 16'd5; fill_val = 8'h99; request = 1'b1;
    @(posedge clk);
    q.delete();
    q.push_back(mk(7'b0000110, 16'h0, 16'h0, 8'h0));
    @(negedge clk);
    rst = 1'b0; request = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_writes", 32'(n_wr - a_wr), 32'd9);
    chk("abort_no_done", 32'(done_at > acc), 32'd0);
    for (int i = 0; i < 9; i++) chk("abort_ram", 32'(ram[16'(i)]), 32'h77);
    chk("abort_ram_next", 32'(ram[16'd9]), 32'h3C);
    chk("abort_req_ignored", 32'(ram[16'h0200]), 32'h3C);

    bad = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== mm[i]) bad++;
    chk("ram_vs_model", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
